// File: rtl/rs_station_pkg.sv
// Shared types for the reservation station: the scheduler entry layout,
// the tag width, the TAG_NONE marker and the default depth.
package rs_station_pkg;

  localparam int TAG_W = 4;
  localparam int RS_DEPTH = 8;
  localparam logic [TAG_W-1:0] TAG_NONE = '1;

  typedef struct packed {
    logic [1:0]       fu_type;
    logic [3:0]       alu_ctrl;
    logic             branch;
    logic [2:0]       branch_type;
    logic [31:0]      store_imm;
    logic [TAG_W-1:0] rob_tag;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [31:0]      vj;
    logic [31:0]      vk;
  } rs_scheduler_s;

endpackage

// File: rtl/rs_station_if.sv
// Bus bundle of rs_station: alloc side, CDB snoop, flush and issue port.
// slave = station side, master = driver side (scheduler/CDB/FU model).
interface rs_station_if
  import rs_station_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH
);

  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid_i;
  rs_scheduler_s    in_entry_i;
  logic             rs_full_o;
  logic [CW-1:0]    rs_count_o;
  logic             cdb_valid_i;
  logic [TAG_W-1:0] cdb_tag_i;
  logic [31:0]      cdb_value_i;
  logic             flush_i;
  logic             issue_ready_i;
  logic             issue_valid_o;
  rs_scheduler_s    issue_entry_o;

  modport slave (
    input  in_valid_i, in_entry_i,
    input  cdb_valid_i, cdb_tag_i, cdb_value_i,
    input  flush_i, issue_ready_i,
    output rs_full_o, rs_count_o,
    output issue_valid_o, issue_entry_o
  );

  modport master (
    output in_valid_i, in_entry_i,
    output cdb_valid_i, cdb_tag_i, cdb_value_i,
    output flush_i, issue_ready_i,
    input  rs_full_o, rs_count_o,
    input  issue_valid_o, issue_entry_o
  );

endinterface

// File: rtl/rs_station_slot.sv
// One reservation-station slot (rs_entry_slot): holds, shifts in or loads
// an entry, snoops the CDB on whichever entry is written, reports ready.
// Ports: load/shift controls, upper-slot data, new entry, CDB, valid/entry/ready.
// With RS_ISSUE_BYPASS_EN also exports a CDB-bypassed ready/entry view.
module rs_entry_slot
  import rs_station_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             shift,
  input  logic             up_valid,
  input  rs_scheduler_s    up_entry,
  input  rs_scheduler_s    new_entry,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  output logic             valid,
  output rs_scheduler_s    entry,
`ifdef RS_ISSUE_BYPASS_EN
  output logic             byp_ready,
  output rs_scheduler_s    byp_entry,
`endif
  output logic             ready
);

  logic          src_v;
  rs_scheduler_s src_e;
  rs_scheduler_s nxt_e;

  // Load beats shift: at the alloc slot the shift would only bring in an
  // empty slot from above.
  always_comb begin
    src_v = valid;
    src_e = entry;
    if (load) begin
      src_v = 1'b1;
      src_e = new_entry;
    end else if (shift) begin
      src_v = up_valid;
      src_e = up_entry;
    end
  end

  // Wakeup is applied to the data being written, so a broadcast is
  // caught whether the entry holds, moves down or arrives this cycle.
  always_comb begin
    nxt_e = src_e;
    if (cdb_valid && src_e.qj == cdb_tag) begin
      nxt_e.vj = cdb_value;
      nxt_e.qj = TAG_NONE;
    end
    if (cdb_valid && src_e.qk == cdb_tag) begin
      nxt_e.vk = cdb_value;
      nxt_e.qk = TAG_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid <= 1'b0;
    end else begin
      valid <= src_v;
      entry <= nxt_e;
    end
  end

  assign ready = valid
    && entry.qj == TAG_NONE
    && entry.qk == TAG_NONE;

`ifdef RS_ISSUE_BYPASS_EN
  logic j_hit;
  logic k_hit;

  assign j_hit = cdb_valid && entry.qj == cdb_tag;
  assign k_hit = cdb_valid && entry.qk == cdb_tag;

  assign byp_ready = valid
    && (entry.qj == TAG_NONE || j_hit)
    && (entry.qk == TAG_NONE || k_hit);

  always_comb begin
    byp_entry = entry;
    if (j_hit) begin
      byp_entry.vj = cdb_value;
      byp_entry.qj = TAG_NONE;
    end
    if (k_hit) begin
      byp_entry.vk = cdb_value;
      byp_entry.qk = TAG_NONE;
    end
  end
`endif

endmodule

// File: rtl/rs_station.sv
// Reservation station: collapsing queue of DEPTH slots, slot 0 oldest,
// CDB wakeup, oldest-ready issue over valid/ready.
// Ports: clk_i, reset_i (sync, active-high), bus (rs_station_if.slave).
// Option: RS_ISSUE_BYPASS_EN lets a CDB hit make a slot ready same cycle.
module rs_station
  import rs_station_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH
)(
  input logic         clk_i,
  input logic         reset_i,
  rs_station_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] count_q;
  logic          full;
  logic          accept;
  logic          fire;
  logic          any_rdy;
  logic [IW-1:0] sel;
  logic [CW-1:0] alloc_pos;

  logic [DEPTH-1:0] slot_v;
  logic [DEPTH-1:0] slot_rdy;
  logic [DEPTH-1:0] up_v;
  logic [DEPTH-1:0] sel_rdy;
  rs_scheduler_s    slot_e  [DEPTH];
  rs_scheduler_s    up_e    [DEPTH];
  rs_scheduler_s    sel_e   [DEPTH];

  assign full = (count_q == CW'(DEPTH));
  assign accept = bus.in_valid_i && !full
    && bus.in_entry_i.fu_type != 2'd0;
  assign fire = any_rdy && bus.issue_ready_i;

  // On fire everything above the issued slot drops by one, so the new
  // entry goes one below the current count.
  assign alloc_pos = count_q - CW'(fire);

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_slot
      if (i == DEPTH - 1) begin : g_top
        assign up_v[i] = 1'b0;
        assign up_e[i] = '0;
      end else begin : g_mid
        assign up_v[i] = slot_v[i+1];
        assign up_e[i] = slot_e[i+1];
      end

      rs_entry_slot u_slot (
        .clk       (clk_i),
        .reset     (reset_i),
        .flush     (bus.flush_i),
        .load      (accept && alloc_pos == CW'(i)),
        .shift     (fire && IW'(i) >= sel),
        .up_valid  (up_v[i]),
        .up_entry  (up_e[i]),
        .new_entry (bus.in_entry_i),
        .cdb_valid (bus.cdb_valid_i),
        .cdb_tag   (bus.cdb_tag_i),
        .cdb_value (bus.cdb_value_i),
        .valid     (slot_v[i]),
        .entry     (slot_e[i]),
`ifdef RS_ISSUE_BYPASS_EN
        .byp_ready (sel_rdy[i]),
        .byp_entry (sel_e[i]),
`endif
        .ready     (slot_rdy[i])
      );

`ifndef RS_ISSUE_BYPASS_EN
      assign sel_rdy[i] = slot_rdy[i];
      assign sel_e[i] = slot_e[i];
`endif
    end
  endgenerate

  // Lowest index wins: scan from the top so the oldest ready is last.
  always_comb begin
    sel = '0;
    any_rdy = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (sel_rdy[k]) begin
        sel = IW'(k);
        any_rdy = 1'b1;
      end
    end
  end

  always_comb begin
    bus.issue_entry_o = sel_e[sel];
    bus.issue_entry_o.qj = TAG_NONE;
    bus.issue_entry_o.qk = TAG_NONE;
  end

  assign bus.issue_valid_o = any_rdy;
  assign bus.rs_full_o = full;
  assign bus.rs_count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || bus.flush_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(accept) - CW'(fire);
    end
  end

  // Upstream is expected to honour rs_full_o and never send LSU ops;
  // violations are dropped and flagged.
  always_ff @(posedge clk_i) begin
    if (!reset_i && !bus.flush_i && bus.in_valid_i) begin
      a_full: assert (!full)
        else $warning("rs_station: alloc while full dropped");
      a_fu: assert (bus.in_entry_i.fu_type != 2'd0)
        else $warning("rs_station: fu_type 0 alloc dropped");
    end
  end

endmodule
